cmd_stream_writer: RTL and testbench

Producer end of the command queue that feeds `top`: streams a preloaded command image from a synchronous command ROM into the command FIFO's write port, and honours the two-phase decomp/recomp barrier in hardware. Phase-1 (decomp) commands are pushed first. Phase-2 (recomp) commands are released only after the FIFO has drained and `top` reports `finished_task`. Sits between the command ROM and `u_cmd_queue`, replacing the bench-side pointer manipulation of the queue.

---
 rtl/cmd_stream_writer.sv | 172 +++++++++++++++++
 tb/tb_cmd_stream_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_stream_writer.sv
// cmd_stream_writer: streams a command image from a synchronous ROM into the
// command FIFO in two phases (decomp, then recomp) with a drain barrier
// between them. Start-to-first-write is 2 cycles. Throughput is 1 word/cycle.
// FIFO full stalls the pop, and ROM reads stop within one cycle. At most two
// words are ever buffered.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_start, i_total_cmds,
//   i_phase1_cmds              run request; counts are sampled on start
//   o_src_rd/o_src_addr,
//   i_src_data                 ROM port; data returns one cycle after the read
//   o_fifo_write/o_fifo_data,
//   i_fifo_full/i_fifo_empty   FIFO write port and its status flags
//   i_finished_task            downstream idle indication for the barrier
//   o_busy/o_phase/o_done,
//   o_written                  run status
module cmd_stream_writer #(
  parameter int CMD_W  = 64,
  parameter int ADDR_W = 18,
  parameter int GUARD  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_total_cmds,
  input  logic [ADDR_W-1:0] i_phase1_cmds,
  output logic              o_src_rd,
  output logic [ADDR_W-1:0] o_src_addr,
  input  logic [CMD_W-1:0]  i_src_data,
  output logic              o_fifo_write,
  output logic [CMD_W-1:0]  o_fifo_data,
  input  logic              i_fifo_full,
  input  logic              i_fifo_empty,
  input  logic              i_finished_task,
  output logic              o_busy,
  output logic              o_phase,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_written
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED1, S_DRAIN1, S_FEED2, S_DRAIN2, S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] total_q, p1_q, addr_q, written_q;
  logic [GW-1:0]     guard_q;
  logic              busy_q, phase_q, done_q;
  logic [1:0]        cnt_q;
  logic              infl_q;
  logic [CMD_W-1:0]  buf0_q, buf1_q;

  logic              feeding, reads_left, avail, pop, issue, feed_done, guard_ok;
  logic [ADDR_W-1:0] rd_end, p1_clamp;
  logic [1:0]        cnt_d;
  logic [CMD_W-1:0]  head;

  assign p1_clamp   = (i_phase1_cmds > i_total_cmds) ? i_total_cmds : i_phase1_cmds;
  assign feeding    = (state_q == S_FEED1) || (state_q == S_FEED2);
  // The address runs continuously across both phases; each phase stops at its end.
  assign rd_end     = (state_q == S_FEED2) ? total_q : p1_q;
  assign reads_left = (addr_q != rd_end);

  // A word in flight can be written straight through when the buffer is empty,
  // which is what gives the 2-cycle start-to-write latency.
  assign avail = (cnt_q != 2'd0) || infl_q;
  assign head  = (cnt_q != 2'd0) ? buf0_q : i_src_data;
  assign pop   = avail && !i_fifo_full && !i_rst;
  // Buffer plus in-flight occupancy never exceeds 2, so this fits in 2 bits.
  assign cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue = feeding && reads_left && (cnt_d < 2'd2) && !i_rst;

  assign feed_done = !reads_left && (cnt_q == 2'd0) && !infl_q;
  assign guard_ok  = i_fifo_empty && (guard_q == GW'(GUARD));

  assign o_src_rd     = issue;
  assign o_src_addr   = addr_q;
  assign o_fifo_write = pop;
  assign o_fifo_data  = pop ? head : '0;
  assign o_busy       = busy_q;
  assign o_phase      = phase_q;
  assign o_done       = done_q;
  assign o_written    = written_q;

  // Datapath: read address, in-flight flag, 2-entry buffer, write counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q    <= '0;
      written_q <= '0;
      cnt_q     <= 2'd0;
      infl_q    <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      infl_q <= issue;
      cnt_q  <= cnt_d;
      if (state_q == S_IDLE && i_start) begin
        addr_q    <= '0;
        written_q <= '0;
      end else begin
        if (issue) addr_q <= addr_q + ADDR_W'(1);
        if (pop) written_q <= written_q + ADDR_W'(1);
      end
      if (pop) begin
        buf0_q <= (cnt_q == 2'd2) ? buf1_q : i_src_data;
        buf1_q <= i_src_data;
      end else if (infl_q) begin
        if (cnt_q == 2'd0) buf0_q <= i_src_data;
        else               buf1_q <= i_src_data;
      end
    end
  end

  // Control FSM. The guard counter saturates at GUARD and restarts on any
  // non-empty cycle; i_finished_task is only looked at once it is saturated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      total_q <= '0;
      p1_q    <= '0;
      guard_q <= '0;
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            total_q <= i_total_cmds;
            p1_q    <= p1_clamp;
            guard_q <= '0;
            busy_q  <= 1'b1;
            phase_q <= 1'b0;
            state_q <= (p1_clamp == '0) ? S_DRAIN1 : S_FEED1;
          end
        end
        S_FEED1, S_FEED2: begin
          if (feed_done) begin
            guard_q <= '0;
            state_q <= (state_q == S_FEED1) ? S_DRAIN1 : S_DRAIN2;
          end
        end
        S_DRAIN1, S_DRAIN2: begin
          if (!i_fifo_empty) begin
            guard_q <= '0;
          end else if (guard_q != GW'(GUARD)) begin
            guard_q <= guard_q + GW'(1);
          end else if (guard_ok && i_finished_task) begin
            guard_q <= '0;
            if (state_q == S_DRAIN1) begin
              phase_q <= 1'b1;
              state_q <= (total_q == p1_q) ? S_DRAIN2 : S_FEED2;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          phase_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_stream_writer.sv
module tb_cmd_stream_writer;
  localparam int CMD_W  = 64;
  localparam int ADDR_W = 18;
  localparam int GUARD  = 2;
  localparam int CAP    = 4;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b1;
  logic [ADDR_W-1:0] i_total_cmds = 18'd8;
  logic [ADDR_W-1:0] i_phase1_cmds = 18'd8;
  logic              o_src_rd;
  logic [ADDR_W-1:0] o_src_addr;
  logic [CMD_W-1:0]  i_src_data = JUNK;
  logic              o_fifo_write;
  logic [CMD_W-1:0]  o_fifo_data;
  logic              i_fifo_full = 1'b0;
  logic              i_fifo_empty = 1'b1;
  logic              i_finished_task = 1'b0;
  logic              o_busy, o_phase, o_done;
  logic [ADDR_W-1:0] o_written;

  cmd_stream_writer #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .GUARD(GUARD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_total_cmds(i_total_cmds), .i_phase1_cmds(i_phase1_cmds),
    .o_src_rd(o_src_rd), .o_src_addr(o_src_addr), .i_src_data(i_src_data),
    .o_fifo_write(o_fifo_write), .o_fifo_data(o_fifo_data),
    .i_fifo_full(i_fifo_full), .i_fifo_empty(i_fifo_empty),
    .i_finished_task(i_finished_task),
    .o_busy(o_busy), .o_phase(o_phase), .o_done(o_done), .o_written(o_written)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rom_word(input int a);
    logic [31:0] u;
    u = a;
    return {16'hC0DE, u[15:0], (u * 32'h9E37_79B9) ^ 32'h1234_5678};
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Environment: synchronous ROM and a CAP-deep FIFO with a consumer.
  logic cons_en = 1'b1;
  logic bp_en = 1'b0;
  int   fsize = 0;
  initial begin
    logic rd_n, w_n, c_n;
    logic [ADDR_W-1:0] addr_n;
    forever begin
      @(negedge i_clk);
      rd_n = o_src_rd; addr_n = o_src_addr; w_n = o_fifo_write;
      c_n = cons_en && (fsize > 0);
      @(posedge i_clk);
      #1;
      i_src_data = rd_n ? rom_word(int'(addr_n)) : JUNK;
      fsize = fsize + (w_n ? 1 : 0) - (c_n ? 1 : 0);
      i_fifo_empty = (fsize == 0);
      i_fifo_full = (fsize >= CAP) || (bp_en && fsize > 0 && $urandom_range(0, 99) < 40);
    end
  end

  // Behavioural model: in-order scoreboard of the command image, plus the
  // barrier rule (GUARD+1 consecutive empty cycles after a phase completes,
  // and finished_task high on the last of them).
  logic exp_busy = 1'b0;
  logic rel1 = 1'b0, rel2 = 1'b0;
  int   mT = 0, mP = 0, writes_seen = 0, reads_seen = 0, empty_run = 0;
  int   start_cyc = 0, done_cyc = -1, tgt;
  int   wcyc [0:31];

  initial forever begin
    @(negedge i_clk);
    if (i_rst) begin
      chk("rst_no_write", 64'(o_fifo_write), 64'(0));
      chk("rst_no_read", 64'(o_src_rd), 64'(0));
      exp_busy = 1'b0; writes_seen = 0; reads_seen = 0;
      rel1 = 1'b0; rel2 = 1'b0; empty_run = 0;
    end else begin
      chk("busy", 64'(o_busy), 64'(exp_busy));
      chk("written", 64'(o_written), 64'(writes_seen));
      if (!exp_busy) begin
        chk("idle_phase", 64'(o_phase), 64'(0));
        chk("idle_done", 64'(o_done), 64'(0));
        chk("idle_rd", 64'(o_src_rd), 64'(0));
        chk("idle_write", 64'(o_fifo_write), 64'(0));
        if (i_start) begin
          exp_busy = 1'b1;
          mT = int'(i_total_cmds);
          mP = (i_phase1_cmds > i_total_cmds) ? int'(i_total_cmds) : int'(i_phase1_cmds);
          writes_seen = 0; reads_seen = 0; rel1 = 1'b0; rel2 = 1'b0;
          empty_run = 0; start_cyc = cyc; done_cyc = -1;
        end
      end else begin
        chk("occupancy_le_2", 64'(reads_seen - writes_seen <= 2), 64'(1));
        if (!rel1) chk("phase_before_barrier", 64'(o_phase), 64'(0));
        if (o_src_rd) begin
          chk("rd_addr", 64'(o_src_addr), 64'(reads_seen));
          chk("rd_in_range", 64'(reads_seen < mT), 64'(1));
          reads_seen++;
        end
        if (o_fifo_write) begin
          chk("wr_not_full", 64'(i_fifo_full), 64'(0));
          chk("wr_in_range", 64'(writes_seen < mT), 64'(1));
          chk("wr_data", o_fifo_data, rom_word(writes_seen));
          if (writes_seen < mP) begin
            chk("wr_phase0", 64'(o_phase), 64'(0));
          end else begin
            chk("wr_phase1", 64'(o_phase), 64'(1));
            chk("wr_after_barrier", 64'(rel1), 64'(1));
          end
          if (writes_seen < 32) wcyc[writes_seen] = cyc - start_cyc;
        end
        if (o_done) begin
          chk("done_all_written", 64'(writes_seen), 64'(mT));
          chk("done_after_barrier", 64'(rel2), 64'(1));
          done_cyc = cyc - start_cyc;
        end
        if (!rel2) begin
          tgt = rel1 ? mT : mP;
          if (i_fifo_empty && !o_fifo_write && writes_seen == tgt) empty_run++;
          else empty_run = 0;
          if (empty_run > GUARD && i_finished_task) begin
            if (!rel1) begin rel1 = 1'b1; empty_run = 0; end
            else rel2 = 1'b1;
          end
        end
        if (o_fifo_write) writes_seen++;
        if (o_done) exp_busy = 1'b0;
      end
    end
  end

  task automatic do_start(input int t, input int p);
    @(posedge i_clk); #1;
    i_total_cmds = ADDR_W'(t);
    i_phase1_cmds = ADDR_W'(p);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge i_clk);
      if (o_done) got = 1'b1;
    end
    chk(name, 64'(got), 64'(1));
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic found;
    // Reset held with start high: everything quiet.
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_phase", 64'(o_phase), 64'(0));
      chk("rst_done", 64'(o_done), 64'(0));
      chk("rst_written", 64'(o_written), 64'(0));
      chk("rst_addr", 64'(o_src_addr), 64'(0));
      chk("rst_data", o_fifo_data, 64'(0));
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("post_rst_busy", 64'(o_busy), 64'(0));

    // Single phase, T=P=8: writes on cycles 2..9, done after two guarded drains.
    i_finished_task = 1'b1;
    do_start(8, 8);
    wait_done("single_done", 300);
    for (int i = 0; i < 8; i++) chk("single_wr_cycle", 64'(wcyc[i]), 64'(i + 2));
    chk("single_done_cycle", 64'(done_cyc), 64'(17));
    chk("single_written", 64'(o_written), 64'(8));
    chk("single_idle_after", 64'(o_busy), 64'(0));

    // Backpressure, T=P=20.
    bp_en = 1'b1;
    do_start(20, 20);
    wait_done("bp_done", 800);
    chk("bp_written", 64'(o_written), 64'(20));
    bp_en = 1'b0;

    // Phase barrier, T=12 P=5, finished_task low for 50 cycles after drain.
    i_finished_task = 1'b0;
    do_start(12, 5);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge i_clk);
      if (o_written == 18'd5 && i_fifo_empty) found = 1'b1;
    end
    chk("barrier_drained", 64'(found), 64'(1));
    repeat (50) @(negedge i_clk);
    chk("barrier_hold_written", 64'(o_written), 64'(5));
    chk("barrier_hold_phase", 64'(o_phase), 64'(0));
    chk("barrier_hold_busy", 64'(o_busy), 64'(1));
    @(posedge i_clk); #1;
    i_finished_task = 1'b1;
    wait_done("barrier_done", 300);
    chk("barrier_written", 64'(o_written), 64'(12));

    // Edge counts.
    do_start(4, 0);
    wait_done("p0_done", 300);
    chk("p0_written", 64'(o_written), 64'(4));
    do_start(6, 9);
    wait_done("clamp_done", 300);
    chk("clamp_written", 64'(o_written), 64'(6));
    do_start(0, 0);
    wait_done("t0_done", 300);
    chk("t0_written", 64'(o_written), 64'(0));

    // Reset during FEED2 with a read in flight, then replay from address 0.
    do_start(12, 5);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge i_clk);
      if (o_phase && o_src_rd) found = 1'b1;
    end
    chk("midrst_reached_feed2", 64'(found), 64'(1));
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_write_in_rst", 64'(o_fifo_write), 64'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_write_after", 64'(o_fifo_write), 64'(0));
    chk("midrst_busy", 64'(o_busy), 64'(0));
    chk("midrst_addr", 64'(o_src_addr), 64'(0));
    chk("midrst_written", 64'(o_written), 64'(0));
    do_start(4, 4);
    wait_done("replay_done", 300);
    chk("replay_first_wr_cycle", 64'(wcyc[0]), 64'(2));
    chk("replay_written", 64'(o_written), 64'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
